uart_frame_rx: RTL and testbench
================================

# uart_frame_rx

Serial front end that feeds the pixel-processing controller. Deserializes an 8N1 UART line, hunts for a sync byte, and delivers one fixed-length pixel frame as a one-cycle `start` pulse followed by exactly `FRAME_LEN` `rx_data`/`rx_valid` beats. Its outputs connect directly to the controller's `start`, `rx_data` and `rx_valid` inputs.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200); must be ≥ 4.
- `FRAME_LEN`, 32: payload bytes per frame.
- `SYNC_BYTE`, 8'hA5: frame header byte.
- `IDLE_TIMEOUT`, 20: bit periods of idle line tolerated between payload bytes.

- `clk`  in  1  single clock; everything is clocked on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `uart_rx`  in  1  asynchronous serial line; idles high.
- `start`  out  1  one-cycle pulse when a sync byte is accepted.
- `rx_data`  out  8  payload byte; holds its value between beats.
- `rx_valid`  out  1  one-cycle qualifier for `rx_data`.
- `frame_err`  out  1  one-cycle pulse when a frame is aborted.
- `busy`  out  1  high while in PAYLOAD.

## Operation
- Input conditioning: 2-flop synchronizer on `uart_rx`. Both flops reset to 1. All logic uses the synchronized value.
- Bit FSM has four states: B_IDLE, B_START, B_DATA, B_STOP.
  - B_IDLE: a synchronized 0 moves to B_START and clears the bit counter.
  - B_START: after `CLKS_PER_BIT/2` cycles, re-sample the line. If it is 0, go to B_DATA. If it is 1, treat it as a glitch and return to B_IDLE with no byte.
  - B_DATA: sample every `CLKS_PER_BIT` cycles, LSB first, into a shift register. After 8 bits, go to B_STOP.
  - B_STOP: sample after `CLKS_PER_BIT` cycles. A 1 raises internal `byte_ok` for one cycle; a 0 raises `stop_err` for one cycle. Either way, return to B_IDLE. A new start bit can be detected on the next cycle.
- Frame FSM has two states: F_HUNT, F_PAYLOAD.
  - F_HUNT, `byte_ok` with byte == `SYNC_BYTE`: pulse `start`, clear the beat count, go to F_PAYLOAD.
  - F_HUNT, any other byte or `stop_err`: ignore silently.
  - F_PAYLOAD, `byte_ok`: drive `rx_data` = byte and `rx_valid` = 1 for one cycle, then increment the count. On beat `FRAME_LEN` (count == `FRAME_LEN-1`), return to F_HUNT. A byte equal to `SYNC_BYTE` is ordinary payload.
  - F_PAYLOAD, `stop_err`: pulse `frame_err`, discard the byte, return to F_HUNT.
  - F_PAYLOAD timeout: the idle counter counts cycles while the bit FSM is in B_IDLE and resets on every start-bit detection. When it reaches `IDLE_TIMEOUT*CLKS_PER_BIT`, pulse `frame_err` and return to F_HUNT.
- `busy` = (frame state == F_PAYLOAD).
- Counter widths use `$clog2` of their maximum value. Beat count is `$clog2(FRAME_LEN)` bits and never wraps, because the exit happens at `FRAME_LEN-1`.

## Timing
- Reset values: `start` = 0, `rx_valid` = 0, `rx_data` = 8'h00, `frame_err` = 0, `busy` = 0. Bit FSM is in B_IDLE, frame FSM is in F_HUNT, all counters are 0.
- Reset mid-byte or mid-frame discards everything. No pulse is emitted on the cycle after reset releases.
- Latency: `rx_valid` or `start` rises 1 cycle after the stop-bit sample. The stop-bit sample occurs 2 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` cycles after the line's falling edge.
- Pulse width and exclusivity: `start`, `rx_valid` and `frame_err` are each exactly 1 cycle wide and mutually exclusive in any cycle.
- Ordering: the first `rx_valid` follows `start` by at least one byte time. Consecutive `rx_valid` pulses are ≥ 10·`CLKS_PER_BIT` apart.
- Flow control: there is no backpressure. Downstream must accept every beat.
- Simultaneous events: timeout expiry and start-bit detection in the same cycle resolve in favour of the start bit (no timeout). On the last beat, the return to F_HUNT happens on the same edge as `rx_valid`. A sync byte that follows immediately is accepted.

## Test plan
All scenarios use `CLKS_PER_BIT`=4, `FRAME_LEN`=32, `IDLE_TIMEOUT`=20.
- **Nominal frame.** Send 0xA5 then 32 bytes, all 0 except [15]=100, [16]=200, [17]=250 → exactly one `start`, then 32 `rx_valid` beats in order with those values. `busy` falls with beat 32 and `frame_err` never asserts.
- **Hunt filtering.** Send 0x00, 0x5A, 0xFF, then a full frame → no `start` or `rx_valid` before the 0xA5 byte, then a normal frame.
- **Glitch rejection.** A 1-cycle low pulse on an idle line, then a frame → no spurious byte, and the frame is received intact.
- **Stop error.** In the payload, byte 10 has stop bit = 0 → exactly 10 `rx_valid` beats, one `frame_err`, `busy` = 0. A following good frame delivers 32 beats.
- **Timeout.** Send sync plus 5 bytes, then hold the line high → `frame_err` exactly 80 cycles after the bit FSM returns to B_IDLE, and `busy` = 0. Also, a payload byte of 0xA5 is delivered as data.
- **Reset mid-frame.** Assert `rst` in the middle of byte 7 → all outputs 0 the next cycle, no further beats. A new sync plus frame works.

Source files
------------

// File: rtl/uart_frame_rx.sv
// 8N1 UART receiver with sync-byte framing: hunts for SYNC_BYTE, then emits a
// start pulse and FRAME_LEN payload beats, aborting on stop-bit errors or idle timeout.
module uart_frame_rx #(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         FRAME_LEN    = 32,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         IDLE_TIMEOUT = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       start,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF_BIT    = CLKS_PER_BIT / 2;
  localparam int TIMEOUT_CYC = IDLE_TIMEOUT * CLKS_PER_BIT;
  localparam int CLK_W       = $clog2(CLKS_PER_BIT);
  localparam int IDLE_W      = $clog2(TIMEOUT_CYC + 1);
  localparam int BEAT_W      = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [1:0] B_IDLE  = 2'd0;
  localparam logic [1:0] B_START = 2'd1;
  localparam logic [1:0] B_DATA  = 2'd2;
  localparam logic [1:0] B_STOP  = 2'd3;

  localparam logic [0:0] F_HUNT    = 1'b0;
  localparam logic [0:0] F_PAYLOAD = 1'b1;

  logic [1:0]        sync_reg;
  logic              rx_sync;

  logic [1:0]        bit_state_reg, bit_state_next;
  logic [CLK_W-1:0]  clk_cnt_reg, clk_cnt_next;
  logic [2:0]        bit_idx_reg, bit_idx_next;
  logic [7:0]        data_sr_reg, data_sr_next;
  logic              start_det;
  logic              byte_ok;
  logic              stop_err;

  logic [IDLE_W-1:0] idle_cnt_reg, idle_cnt_next;
  logic              timeout_hit;

  logic [0:0]        frame_state_reg, frame_state_next;
  logic [BEAT_W-1:0] beat_cnt_reg, beat_cnt_next;
  logic              start_reg, start_next;
  logic              rx_valid_reg, rx_valid_next;
  logic              frame_err_reg, frame_err_next;
  logic [7:0]        rx_data_reg, rx_data_next;

  assign rx_sync = sync_reg[1];

  // Bit-level receiver: one sample per bit, taken mid-bit after the half-bit start check.
  always_comb begin
    bit_state_next = bit_state_reg;
    clk_cnt_next   = clk_cnt_reg;
    bit_idx_next   = bit_idx_reg;
    data_sr_next   = data_sr_reg;
    start_det      = 1'b0;
    byte_ok        = 1'b0;
    stop_err       = 1'b0;
    case (bit_state_reg)
      B_IDLE: begin
        if (!rx_sync) begin
          start_det      = 1'b1;
          bit_state_next = B_START;
          clk_cnt_next   = '0;
          bit_idx_next   = '0;
        end
      end
      B_START: begin
        if (clk_cnt_reg == CLK_W'(HALF_BIT - 1)) begin
          clk_cnt_next   = '0;
          bit_state_next = rx_sync ? B_IDLE : B_DATA;
        end else begin
          clk_cnt_next = clk_cnt_reg + 1'b1;
        end
      end
      B_DATA: begin
        if (clk_cnt_reg == CLK_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_next = '0;
          data_sr_next = {rx_sync, data_sr_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) begin
            bit_state_next = B_STOP;
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + 1'b1;
        end
      end
      B_STOP: begin
        if (clk_cnt_reg == CLK_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_next   = '0;
          bit_state_next = B_IDLE;
          if (rx_sync) begin
            byte_ok = 1'b1;
          end else begin
            stop_err = 1'b1;
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + 1'b1;
        end
      end
      default: begin
        bit_state_next = B_IDLE;
      end
    endcase
  end

  // Idle counter saturates so it cannot wrap while hunting; a start bit always wins over expiry.
  always_comb begin
    idle_cnt_next = idle_cnt_reg;
    if (bit_state_reg != B_IDLE || start_det) begin
      idle_cnt_next = '0;
    end else if (idle_cnt_reg != IDLE_W'(TIMEOUT_CYC)) begin
      idle_cnt_next = idle_cnt_reg + 1'b1;
    end
  end

  assign timeout_hit = (frame_state_reg == F_PAYLOAD) && (bit_state_reg == B_IDLE) &&
                       !start_det && (idle_cnt_reg == IDLE_W'(TIMEOUT_CYC - 1));

  always_comb begin
    frame_state_next = frame_state_reg;
    beat_cnt_next    = beat_cnt_reg;
    start_next       = 1'b0;
    rx_valid_next    = 1'b0;
    frame_err_next   = 1'b0;
    rx_data_next     = rx_data_reg;
    case (frame_state_reg)
      F_HUNT: begin
        if (byte_ok && data_sr_reg == SYNC_BYTE) begin
          start_next       = 1'b1;
          beat_cnt_next    = '0;
          frame_state_next = F_PAYLOAD;
        end
      end
      F_PAYLOAD: begin
        if (byte_ok) begin
          rx_valid_next = 1'b1;
          rx_data_next  = data_sr_reg;
          // Leave on the final beat instead of incrementing, so the count never wraps.
          if (beat_cnt_reg == BEAT_W'(FRAME_LEN - 1)) begin
            frame_state_next = F_HUNT;
          end else begin
            beat_cnt_next = beat_cnt_reg + 1'b1;
          end
        end else if (stop_err || timeout_hit) begin
          frame_err_next   = 1'b1;
          frame_state_next = F_HUNT;
        end
      end
      default: begin
        frame_state_next = F_HUNT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg        <= 2'b11;
      bit_state_reg   <= B_IDLE;
      clk_cnt_reg     <= '0;
      bit_idx_reg     <= '0;
      data_sr_reg     <= '0;
      idle_cnt_reg    <= '0;
      frame_state_reg <= F_HUNT;
      beat_cnt_reg    <= '0;
      start_reg       <= 1'b0;
      rx_valid_reg    <= 1'b0;
      frame_err_reg   <= 1'b0;
      rx_data_reg     <= '0;
    end else begin
      sync_reg        <= {sync_reg[0], uart_rx};
      bit_state_reg   <= bit_state_next;
      clk_cnt_reg     <= clk_cnt_next;
      bit_idx_reg     <= bit_idx_next;
      data_sr_reg     <= data_sr_next;
      idle_cnt_reg    <= idle_cnt_next;
      frame_state_reg <= frame_state_next;
      beat_cnt_reg    <= beat_cnt_next;
      start_reg       <= start_next;
      rx_valid_reg    <= rx_valid_next;
      frame_err_reg   <= frame_err_next;
      rx_data_reg     <= rx_data_next;
    end
  end

  assign start     = start_reg;
  assign rx_valid  = rx_valid_reg;
  assign frame_err = frame_err_reg;
  assign rx_data   = rx_data_reg;
  assign busy      = (frame_state_reg == F_PAYLOAD);

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: directed byte table, hand-written corner sequences and
// randomized byte streams checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_frame_rx;

  localparam int         CPB      = 4;
  localparam int         FLEN     = 32;
  localparam logic [7:0] SYNC     = 8'hA5;
  localparam int         TO       = 20;
  // Cycles from the line's falling edge to the stop-bit sample.
  localparam int         STOP_OFS = 2 + CPB / 2 + 9 * CPB;
  localparam int K_NONE = 0, K_START = 1, K_BEAT = 2, K_FERR = 3;
  localparam int NV = 48;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       start, rx_valid, frame_err, busy;
  logic [7:0] rx_data;

  uart_frame_rx #(.CLKS_PER_BIT(CPB), .FRAME_LEN(FLEN), .SYNC_BYTE(SYNC), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int kind; logic [7:0] data; int cyc; logic busy_at; } ev_t;
  typedef struct { logic [7:0] b; logic stop; int kind; logic busy_after; } vec_t;
  typedef struct { logic [7:0] b; logic stop; int gap; } item_t;

  ev_t   obs_q[$];
  ev_t   exp_q[$];
  item_t items[$];
  vec_t  vecs[NV];
  int    nvec = 0;
  int    checks = 0, failures = 0;
  int    excl_err = 0, width_err = 0;
  int    last_fall = 0;
  logic  prev_s = 1'b0, prev_v = 1'b0, prev_e = 1'b0;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    ev_t e;
    if ($countones({start, rx_valid, frame_err}) > 1) excl_err++;
    if ((start && prev_s) || (rx_valid && prev_v) || (frame_err && prev_e)) width_err++;
    prev_s = start; prev_v = rx_valid; prev_e = frame_err;
    e.cyc = cyc; e.busy_at = busy; e.data = 8'h00;
    if (start)     begin e.kind = K_START; obs_q.push_back(e); end
    if (rx_valid)  begin e.kind = K_BEAT; e.data = rx_data; obs_q.push_back(e); e.data = 8'h00; end
    if (frame_err) begin e.kind = K_FERR; obs_q.push_back(e); end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int gap);
    $display("tx byte=%02h stop=%0b gap=%0d cyc=%0d", b, stop_bit, gap, cyc);
    last_fall = cyc;
    uart_rx = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin uart_rx = b[i]; tick(CPB); end
    uart_rx = stop_bit; tick(CPB);
    uart_rx = 1'b1; tick(gap);
  endtask

  function automatic void add_vec(input logic [7:0] b, input logic s, input int k, input logic ba);
    vecs[nvec] = '{b, s, k, ba};
    nvec++;
  endfunction

  function automatic logic [7:0] pix(input int i);
    return (i == 15) ? 8'd100 : (i == 16) ? 8'd200 : (i == 17) ? 8'd250 : 8'd0;
  endfunction

  function automatic void push_exp(input int k, input logic [7:0] d);
    ev_t e;
    e.kind = k; e.data = d; e.cyc = 0; e.busy_at = 1'b0;
    exp_q.push_back(e);
  endfunction

  // Frame-level reference: a frame is SYNC then FLEN good bytes; a bad stop bit or an
  // idle gap longer than TO bit periods aborts it. The run always ends on a long idle line.
  function automatic void model();
    bit hunting = 1'b1;
    int cnt = 0;
    int idle;
    exp_q.delete();
    for (int i = 0; i < items.size(); i++) begin
      if (i > 0) begin
        idle = 10 * CPB + items[i-1].gap + 2 - STOP_OFS;
        if (!hunting && idle > TO * CPB) begin push_exp(K_FERR, 8'h00); hunting = 1'b1; end
      end
      if (!items[i].stop) begin
        if (!hunting) begin push_exp(K_FERR, 8'h00); hunting = 1'b1; end
      end else if (hunting) begin
        if (items[i].b == SYNC) begin push_exp(K_START, 8'h00); hunting = 1'b0; cnt = 0; end
      end else begin
        push_exp(K_BEAT, items[i].b);
        cnt++;
        if (cnt == FLEN) hunting = 1'b1;
      end
    end
    if (!hunting) push_exp(K_FERR, 8'h00);
  endfunction

  task automatic run_items(input string tag);
    model();
    obs_q.delete();
    foreach (items[i]) send_byte(items[i].b, items[i].stop, items[i].gap);
    tick(120);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_ev%0d", tag, i), obs_q[i].kind * 256 + int'(obs_q[i].data),
            exp_q[i].kind * 256 + int'(exp_q[i].data));
  endtask

  function automatic void add_item(input logic [7:0] b, input logic s, input int gap);
    item_t it;
    it.b = b; it.stop = s; it.gap = gap;
    items.push_back(it);
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=%0d exp=0", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Directed byte table: hunt filtering, nominal frame, stop error mid-frame.
    add_vec(8'h00, 1'b1, K_NONE, 1'b0);
    add_vec(8'h5A, 1'b1, K_NONE, 1'b0);
    add_vec(8'hFF, 1'b1, K_NONE, 1'b0);
    add_vec(SYNC, 1'b1, K_START, 1'b1);
    for (int i = 0; i < FLEN; i++) add_vec(pix(i), 1'b1, K_BEAT, i != FLEN - 1);
    add_vec(SYNC, 1'b1, K_START, 1'b1);
    for (int i = 0; i < 10; i++) add_vec(8'(i * 7 + 1), 1'b1, K_BEAT, 1'b1);
    add_vec(8'h3C, 1'b0, K_FERR, 1'b0);

    rst = 1'b1; tick(5);
    check("rst_start", int'(start), 0);
    check("rst_rx_valid", int'(rx_valid), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_rx_data", int'(rx_data), 0);
    rst = 1'b0;
    obs_q.delete();
    tick(10);
    check("post_rst_quiet", obs_q.size(), 0);

    for (int i = 0; i < nvec; i++) begin
      obs_q.delete();
      send_byte(vecs[i].b, vecs[i].stop, 6);
      check($sformatf("vec%0d_nev", i), obs_q.size(), (vecs[i].kind == K_NONE) ? 0 : 1);
      if (obs_q.size() == 1 && vecs[i].kind != K_NONE) begin
        check($sformatf("vec%0d_kind", i), obs_q[0].kind, vecs[i].kind);
        check($sformatf("vec%0d_data", i), int'(obs_q[0].data),
              (vecs[i].kind == K_BEAT) ? int'(vecs[i].b) : 0);
        check($sformatf("vec%0d_latency", i), obs_q[0].cyc - last_fall, 1 + STOP_OFS);
        check($sformatf("vec%0d_busy_at", i), int'(obs_q[0].busy_at), int'(vecs[i].busy_after));
      end
      check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].busy_after));
    end
    tick(20);

    // Glitch rejection followed by a clean frame.
    obs_q.delete();
    uart_rx = 1'b0; tick(1); uart_rx = 1'b1; tick(40);
    check("glitch_quiet", obs_q.size(), 0);
    items.delete();
    add_item(SYNC, 1'b1, 6);
    for (int i = 0; i < FLEN; i++) add_item(8'($urandom), 1'b1, $urandom_range(4, 12));
    run_items("glitch_frame");

    // Timeout after sync plus five bytes, one of which equals the sync byte.
    items.delete();
    add_item(SYNC, 1'b1, 6);
    add_item(8'h11, 1'b1, 6);
    add_item(SYNC, 1'b1, 6);
    add_item(8'h22, 1'b1, 6);
    add_item(8'h33, 1'b1, 6);
    add_item(8'h44, 1'b1, 6);
    run_items("timeout");
    if (obs_q.size() >= 7)
      check("timeout_delay", obs_q[6].cyc - obs_q[5].cyc, TO * CPB);
    check("timeout_busy", int'(busy), 0);

    // Gap boundary: expiry coinciding with a start bit is not a timeout; one cycle later is.
    items.delete();
    add_item(SYNC, 1'b1, 6);
    add_item(8'h10, 1'b1, 78);
    add_item(8'h20, 1'b1, 79);
    add_item(8'h30, 1'b1, 6);
    run_items("gap_edge");

    // Reset in the middle of byte 7.
    obs_q.delete();
    send_byte(SYNC, 1'b1, 6);
    for (int k = 0; k < 7; k++) send_byte(8'(8'h40 + k), 1'b1, 6);
    check("mid_rst_pre_events", obs_q.size(), 8);
    uart_rx = 1'b0; tick(CPB);
    for (int k = 0; k < 4; k++) begin uart_rx = k[0]; tick(CPB); end
    obs_q.delete();
    rst = 1'b1; uart_rx = 1'b1; tick(1);
    check("mid_rst_start", int'(start), 0);
    check("mid_rst_rx_valid", int'(rx_valid), 0);
    check("mid_rst_frame_err", int'(frame_err), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_rx_data", int'(rx_data), 0);
    rst = 1'b0; tick(150);
    check("mid_rst_quiet", obs_q.size(), 0);
    items.delete();
    add_item(SYNC, 1'b1, 6);
    for (int i = 0; i < FLEN; i++) add_item(8'(i * 3), 1'b1, 5);
    run_items("after_rst");

    // Randomized byte stream.
    items.delete();
    for (int i = 0; i < 200; i++) begin
      int r;
      item_t it;
      r = $urandom_range(0, 99);
      it.b = (r < 12) ? SYNC : 8'($urandom);
      it.stop = ($urandom_range(0, 49) != 0);
      r = $urandom_range(0, 99);
      it.gap = (r < 2) ? 78 : (r < 3) ? 79 : (r < 4) ? 110 : $urandom_range(4, 16);
      items.push_back(it);
    end
    run_items("random");

    check("pulse_exclusive", excl_err, 0);
    check("pulse_width", width_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
